alu_op_decoder: RTL and testbench
=================================

Name: alu_op_decoder

Overview:
- Registered decode stage that turns a 32-bit MIPS instruction into the ALU control bundle: ALUFunc, Signed, operand selects, shift amount and extended immediate.
- Sits between instruction fetch and the ALU/execute operand muxes.
- Uses a valid/ready handshake with a 2-entry skid buffer, so in_ready is a register output.

Parameters:
- IMM_W, 32, width of extended immediate (fixed at 32 for this core).
- DEPTH, 2, skid-buffer entries (only 2 is supported).

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- flush  input  1  synchronous; discards all buffered entries
- in_valid  input  1  instr is valid
- in_ready  output  1  decoder can accept this cycle
- instr  input  32  MIPS instruction word
- out_valid  output  1  decoded bundle is valid
- out_ready  input  1  execute stage consumes the bundle
- alu_func  output  6  ALUFunc code to the ALU
- alu_signed  output  1  Signed input to the ALU
- a_sel  output  1  0 = rs register, 1 = shamt constant
- b_sel  output  2  0 = rt, 1 = imm_ext, 2 = zero, 3 = reserved
- shamt  output  5  shift amount driven as A[4:0] when a_sel=1
- imm_ext  output  32  sign- or zero-extended imm16
- illegal  output  1  unsupported opcode/funct

Behaviour:
- Reset (async, reset=0): both entries invalid; out_valid=0, in_ready=1; alu_func, alu_signed, a_sel, b_sel, shamt, imm_ext and illegal all 0.
- Transfer rules: input transfer when in_valid&in_ready; output transfer when out_valid&out_ready.
- Latency: an instruction accepted at edge N appears on the outputs after edge N (1 cycle), provided the buffer was empty.
- Ordering: strict FIFO order; no reordering and no duplication.
- Buffer state machine, with count in {0,1,2}:
  - EMPTY: accept -> ONE.
  - ONE: accept with no drain -> FULL; drain with no accept -> EMPTY; accept and drain together -> stays ONE.
  - FULL: in_ready=0; drain -> ONE.
  - in_ready is registered: it equals (count<2) as computed on the previous edge.
  - Outputs are driven from the head entry and are held stable while out_valid=1 and out_ready=0.
- flush=1 at an edge: count goes to 0, out_valid=0, in_ready=1. A simultaneous input beat is dropped; flush wins over accept.
- R-type decode (op 0x00), selected by funct:
  - 0x20 add and 0x21 addu -> 000000 (ADD); 0x22 sub and 0x23 subu -> 000001 (SUB).
  - Logic: 0x24 and -> 011000; 0x25 or -> 011110; 0x26 xor -> 010110; 0x27 nor -> 010001.
  - Set-less-than: 0x2A slt and 0x2B sltu -> 110101 (LT).
  - Shifts by shamt, with a_sel=1 and shamt=instr[10:6]: 0x00 sll -> 100000; 0x02 srl -> 100001; 0x03 sra -> 100011.
  - Variable shifts, with a_sel=0: 0x04 sllv, 0x06 srlv, 0x07 srav, using the same codes as the fixed shifts.
  - 0x08 jr and 0x09 jalr -> ADD (result unused).
  - alu_signed=1 for add, sub and slt; 0 for the unsigned forms; 1 for all other R-type ops.
  - b_sel=0 for all R-type ops.
- I-type decode (b_sel=1 unless noted):
  - 0x08 addi: ADD, sign-extend, signed=1.
  - 0x09 addiu: ADD, sign-extend, signed=0.
  - 0x0A slti: LT, sign-extend, signed=1.
  - 0x0B sltiu: LT, sign-extend, signed=0.
  - 0x0C andi, 0x0D ori, 0x0E xori: AND/OR/XOR, zero-extend.
  - 0x0F lui: SLL, a_sel=1, shamt=16, zero-extend.
  - 0x23 lw and 0x2B sw: ADD, sign-extend, signed=0.
- Branch decode (b_sel=0 for beq/bne, b_sel=2 otherwise):
  - 0x04 beq: EQ 110011.
  - 0x05 bne: NEQ 110001.
  - 0x06 blez: LEZ 111101.
  - 0x07 bgtz: GTZ 111111.
  - 0x01 with rt=0 (bltz): LT; with rt=1 (bgez): GEZ 111001.
  - All branches use signed=1.
- Jumps: 0x02 j and 0x03 jal -> ADD, b_sel=0.
- Anything else, including regimm with rt not in {0,1}: illegal=1, alu_func=ADD, signed=0, b_sel=0, a_sel=0; the entry still flows through the buffer normally.
- shamt=0 whenever a_sel=0. imm_ext is always the extension of instr[15:0] as selected above.

Decomposition:
- Shared header alu_defs.vh holds:
  - the ALUFunc codes (ADD, SUB, AND, OR, XOR, NOR, A, SLL, SRL, SRA, EQ, NEQ, LT, LEZ, GEZ, GTZ);
  - the opcode and funct constants;
  - the b_sel encodings.
- The ALU and this block include the same header.
- Sub-module alu_op_table: purely combinational, instr -> bundle. alu_op_decoder wraps it with the skid buffer and handshake logic.

Test Plan:
- addi $t0,$t1,-4 (0x2128FFFC), out_ready=1 -> next cycle: out_valid=1, alu_func=000000, alu_signed=1, b_sel=1, imm_ext=0xFFFFFFFC, illegal=0.
- sra $t0,$t1,3 (0x000940C3) then lui $t0,0x1234 (0x3C081234), back to back:
  - sra -> alu_func=100011, a_sel=1, shamt=3, b_sel=0.
  - lui -> alu_func=100000, shamt=16, imm_ext=0x00001234.
- Three instrs offered with out_ready=0 -> two accepted, then in_ready=0 and the third is held; raise out_ready -> all three emerge in order, one per cycle.
- FULL buffer with flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, and the offered instr never appears.
- 0xFC000000 -> illegal=1, alu_func=000000; bltz (0x05200003) -> alu_func=110101, b_sel=2.
- reset driven low mid-stream, asynchronously between edges -> out_valid=0 and in_ready=1 immediately; after release, the first new instr appears after 1 cycle.

Source files
------------

// File: rtl/alu_op_decoder_pkg.sv
// alu_op_decoder_pkg
//   Shared definitions for the decode stage and the ALU: ALUFunc codes,
//   MIPS opcode/funct constants, b_sel encodings, the decoded control
//   bundle, the skid-buffer state type and the immediate-extension helper.
package alu_op_decoder_pkg;

    localparam int unsigned IMM_W_FIXED = 32;

    typedef enum logic [5:0] {
        ALU_ADD = 6'b000000,
        ALU_SUB = 6'b000001,
        ALU_AND = 6'b011000,
        ALU_OR  = 6'b011110,
        ALU_XOR = 6'b010110,
        ALU_NOR = 6'b010001,
        ALU_A   = 6'b011010,
        ALU_SLL = 6'b100000,
        ALU_SRL = 6'b100001,
        ALU_SRA = 6'b100011,
        ALU_EQ  = 6'b110011,
        ALU_NEQ = 6'b110001,
        ALU_LT  = 6'b110101,
        ALU_LEZ = 6'b111101,
        ALU_GEZ = 6'b111001,
        ALU_GTZ = 6'b111111
    } alu_func_e;

    typedef enum logic [1:0] {
        BSEL_RT   = 2'd0,
        BSEL_IMM  = 2'd1,
        BSEL_ZERO = 2'd2,
        BSEL_RSVD = 2'd3
    } b_sel_e;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } buf_state_e;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef struct packed {
        alu_func_e               func;
        logic                    sgn;
        logic                    a_sel;
        b_sel_e                  b_sel;
        logic [4:0]              shamt;
        logic [IMM_W_FIXED-1:0]  imm_ext;
        logic                    illegal;
    } alu_bundle_t;

    function automatic logic [IMM_W_FIXED-1:0] ext16(input logic [15:0] imm, input logic zext);
        return zext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/alu_op_decoder_if.sv
// alu_op_decoder_if
//   Handshake and control-bundle bus of the decode stage.
//   slave  : decoder side (accepts instr, produces the bundle)
//   master : fetch/execute side (offers instr, consumes the bundle)
//   Signals: flush, in_valid/in_ready/instr, out_valid/out_ready,
//            alu_func, alu_signed, a_sel, b_sel, shamt, imm_ext, illegal.
interface alu_op_decoder_if;
    import alu_op_decoder_pkg::*;

    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            instr;
    logic                   out_valid;
    logic                   out_ready;
    logic [5:0]             alu_func;
    logic                   alu_signed;
    logic                   a_sel;
    logic [1:0]             b_sel;
    logic [4:0]             shamt;
    logic [IMM_W_FIXED-1:0] imm_ext;
    logic                   illegal;

    modport slave (
        input  flush, in_valid, instr, out_ready,
        output in_ready, out_valid, alu_func, alu_signed, a_sel, b_sel,
               shamt, imm_ext, illegal
    );

    modport master (
        output flush, in_valid, instr, out_ready,
        input  in_ready, out_valid, alu_func, alu_signed, a_sel, b_sel,
               shamt, imm_ext, illegal
    );
endinterface

// File: rtl/alu_op_decoder_table.sv
// alu_op_table
//   Purely combinational MIPS instruction -> ALU control bundle decode.
//   Ports: i_instr  (32-bit instruction word)
//          o_bundle (func, signed, a_sel, b_sel, shamt, imm_ext, illegal)
module alu_op_table
    import alu_op_decoder_pkg::*;
(
    input  logic [31:0] i_instr,
    output alu_bundle_t o_bundle
);

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [4:0] w_rt;
    logic [4:0] w_shamt_fld;
    logic       w_unused_rs;
    logic       w_zext;

    assign w_op        = i_instr[31:26];
    assign w_funct     = i_instr[5:0];
    assign w_rt        = i_instr[20:16];
    assign w_shamt_fld = i_instr[10:6];
    assign w_unused_rs = ^i_instr[25:21];

    always_comb begin
        o_bundle       = '0;
        o_bundle.func  = ALU_ADD;
        o_bundle.b_sel = BSEL_RT;
        w_zext         = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                o_bundle.sgn = 1'b1;
                case (w_funct)
                    FN_ADD, FN_JR, FN_JALR: o_bundle.func = ALU_ADD;
                    FN_ADDU: begin o_bundle.func = ALU_ADD; o_bundle.sgn = 1'b0; end
                    FN_SUB:  o_bundle.func = ALU_SUB;
                    FN_SUBU: begin o_bundle.func = ALU_SUB; o_bundle.sgn = 1'b0; end
                    FN_AND:  o_bundle.func = ALU_AND;
                    FN_OR:   o_bundle.func = ALU_OR;
                    FN_XOR:  o_bundle.func = ALU_XOR;
                    FN_NOR:  o_bundle.func = ALU_NOR;
                    FN_SLT:  o_bundle.func = ALU_LT;
                    FN_SLTU: begin o_bundle.func = ALU_LT; o_bundle.sgn = 1'b0; end
                    FN_SLL: begin o_bundle.func = ALU_SLL; o_bundle.a_sel = 1'b1; o_bundle.shamt = w_shamt_fld; end
                    FN_SRL: begin o_bundle.func = ALU_SRL; o_bundle.a_sel = 1'b1; o_bundle.shamt = w_shamt_fld; end
                    FN_SRA: begin o_bundle.func = ALU_SRA; o_bundle.a_sel = 1'b1; o_bundle.shamt = w_shamt_fld; end
                    FN_SLLV: o_bundle.func = ALU_SLL;
                    FN_SRLV: o_bundle.func = ALU_SRL;
                    FN_SRAV: o_bundle.func = ALU_SRA;
                    default: begin o_bundle.illegal = 1'b1; o_bundle.sgn = 1'b0; end
                endcase
            end
            OP_ADDI:  begin o_bundle.b_sel = BSEL_IMM; o_bundle.sgn = 1'b1; end
            OP_ADDIU, OP_LW, OP_SW: o_bundle.b_sel = BSEL_IMM;
            OP_SLTI:  begin o_bundle.func = ALU_LT; o_bundle.b_sel = BSEL_IMM; o_bundle.sgn = 1'b1; end
            OP_SLTIU: begin o_bundle.func = ALU_LT; o_bundle.b_sel = BSEL_IMM; end
            OP_ANDI:  begin o_bundle.func = ALU_AND; o_bundle.b_sel = BSEL_IMM; w_zext = 1'b1; end
            OP_ORI:   begin o_bundle.func = ALU_OR;  o_bundle.b_sel = BSEL_IMM; w_zext = 1'b1; end
            OP_XORI:  begin o_bundle.func = ALU_XOR; o_bundle.b_sel = BSEL_IMM; w_zext = 1'b1; end
            OP_LUI: begin
                o_bundle.func  = ALU_SLL;
                o_bundle.a_sel = 1'b1;
                o_bundle.shamt = 5'd16;
                o_bundle.b_sel = BSEL_IMM;
                w_zext         = 1'b1;
            end
            OP_BEQ:  begin o_bundle.func = ALU_EQ;  o_bundle.sgn = 1'b1; end
            OP_BNE:  begin o_bundle.func = ALU_NEQ; o_bundle.sgn = 1'b1; end
            OP_BLEZ: begin o_bundle.func = ALU_LEZ; o_bundle.sgn = 1'b1; o_bundle.b_sel = BSEL_ZERO; end
            OP_BGTZ: begin o_bundle.func = ALU_GTZ; o_bundle.sgn = 1'b1; o_bundle.b_sel = BSEL_ZERO; end
            OP_REGIMM: begin
                // rt selects bltz (0) / bgez (1); any other rt is unsupported
                if (w_rt == 5'd0) begin
                    o_bundle.func = ALU_LT;  o_bundle.sgn = 1'b1; o_bundle.b_sel = BSEL_ZERO;
                end else if (w_rt == 5'd1) begin
                    o_bundle.func = ALU_GEZ; o_bundle.sgn = 1'b1; o_bundle.b_sel = BSEL_ZERO;
                end else begin
                    o_bundle.illegal = 1'b1;
                end
            end
            OP_J, OP_JAL: o_bundle.func = ALU_ADD;
            default: o_bundle.illegal = 1'b1;
        endcase
        o_bundle.imm_ext = ext16(i_instr[15:0], w_zext);
    end

endmodule

// File: rtl/alu_op_decoder.sv
// alu_op_decoder
//   Registered decode stage: alu_op_table wrapped in a 2-entry skid buffer
//   with a registered in_ready.
//   Ports: clk   (rising edge)
//          reset (asynchronous, active low)
//          bus   (alu_op_decoder_if.slave: flush, input handshake + instr,
//                 output handshake + decoded ALU control bundle)
module alu_op_decoder
    import alu_op_decoder_pkg::*;
#(
    parameter int unsigned IMM_W = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    alu_op_decoder_if.slave   bus
);

    if (IMM_W != IMM_W_FIXED || DEPTH != 2) begin : g_param_check
        $error("alu_op_decoder supports only IMM_W=32 and DEPTH=2");
    end

    alu_bundle_t w_dec;
    alu_bundle_t r_head;
    alu_bundle_t r_tail;
    buf_state_e  r_state;
    logic        r_in_ready;
    logic        r_out_valid;
    logic        w_acc;
    logic        w_drn;

    alu_op_table u_table (
        .i_instr  (bus.instr),
        .o_bundle (w_dec)
    );

    assign w_acc = bus.in_valid & r_in_ready;
    assign w_drn = r_out_valid & bus.out_ready;

    // r_head always holds the oldest entry and drives the outputs directly;
    // r_tail is only occupied in S_FULL.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_EMPTY;
            r_head      <= '0;
            r_tail      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (bus.flush) begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_acc) begin
                        r_head      <= w_dec;
                        r_state     <= S_ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_acc && !w_drn) begin
                        r_tail     <= w_dec;
                        r_state    <= S_FULL;
                        r_in_ready <= 1'b0;
                    end else if (!w_acc && w_drn) begin
                        r_state     <= S_EMPTY;
                        r_out_valid <= 1'b0;
                    end else if (w_acc && w_drn) begin
                        r_head <= w_dec;
                    end
                end
                S_FULL: begin
                    if (w_drn) begin
                        r_head     <= r_tail;
                        r_state    <= S_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.alu_func   = r_head.func;
    assign bus.alu_signed = r_head.sgn;
    assign bus.a_sel      = r_head.a_sel;
    assign bus.b_sel      = r_head.b_sel;
    assign bus.shamt      = r_head.shamt;
    assign bus.imm_ext    = r_head.imm_ext;
    assign bus.illegal    = r_head.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// tb_alu_op_decoder
//   Directed bench for alu_op_decoder with a scoreboard queue of
//   hand-computed expected bundles.
module tb_alu_op_decoder;
    import alu_op_decoder_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    alu_bundle_t exp_q[$];
    alu_bundle_t cur_exp;

    alu_op_decoder_if bus ();

    alu_op_decoder #(
        .IMM_W (32),
        .DEPTH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic alu_bundle_t mk(input alu_func_e f, input logic s, input logic a,
                                       input b_sel_e b, input logic [4:0] sh,
                                       input logic [31:0] imm, input logic ill);
        alu_bundle_t r;
        r.func = f; r.sgn = s; r.a_sel = a; r.b_sel = b;
        r.shamt = sh; r.imm_ext = imm; r.illegal = ill;
        return r;
    endfunction

    function automatic logic [47:0] cur_obs();
        return {bus.alu_func, bus.alu_signed, bus.a_sel, bus.b_sel,
                bus.shamt, bus.imm_ext, bus.illegal};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [31:0] ins, input alu_bundle_t e);
        bus.in_valid = 1'b1;
        bus.instr    = ins;
        cur_exp      = e;
    endtask

    // One clock: score the transfers that happen at the coming edge, then
    // advance to just after it.
    task automatic cycle();
        alu_bundle_t e;
        if (bus.flush) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                chk("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("bundle", 64'(cur_obs()), 64'(e));
                end
            end
            if (bus.in_valid && bus.in_ready) exp_q.push_back(cur_exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) cycle();
        chk("drain_done", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.out_ready = 1'b0;
        cur_exp       = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_bundle", 64'(cur_obs()), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // addi $t0,$t1,-4 with one-cycle latency
        bus.out_ready = 1'b1;
        drive(32'h2128FFFC, mk(ALU_ADD, 1'b1, 1'b0, BSEL_IMM, 5'd0, 32'hFFFFFFFC, 1'b0));
        cycle();
        bus.in_valid = 1'b0;
        chk("addi_latency_valid", 64'(bus.out_valid), 64'd1);
        cycle();
        chk("addi_after_drain", 64'(bus.out_valid), 64'd0);

        // sra then lui back to back
        drive(32'h000940C3, mk(ALU_SRA, 1'b1, 1'b1, BSEL_RT, 5'd3, 32'h000040C3, 1'b0));
        cycle();
        drive(32'h3C081234, mk(ALU_SLL, 1'b0, 1'b1, BSEL_IMM, 5'd16, 32'h00001234, 1'b0));
        cycle();
        bus.in_valid = 1'b0;
        drain();

        // three instrs with out_ready=0: two accepted, third held
        bus.out_ready = 1'b0;
        drive(32'h01095020, mk(ALU_ADD, 1'b1, 1'b0, BSEL_RT, 5'd0, 32'h00005020, 1'b0));
        cycle();
        chk("one_in_ready", 64'(bus.in_ready), 64'd1);
        drive(32'h350800FF, mk(ALU_OR, 1'b0, 1'b0, BSEL_IMM, 5'd0, 32'h000000FF, 1'b0));
        cycle();
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        drive(32'h0109502B, mk(ALU_LT, 1'b0, 1'b0, BSEL_RT, 5'd0, 32'h0000502B, 1'b0));
        cycle();
        cycle();
        chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_queue", 64'(exp_q.size()), 64'd2);
        chk("held_head", 64'(cur_obs()), 64'(exp_q[0]));
        bus.out_ready = 1'b1;
        cycle();
        cycle();
        bus.in_valid = 1'b0;
        drain();
        cycle();
        chk("no_duplicate", 64'(bus.out_valid), 64'd0);

        // flush a full buffer with a simultaneous offer
        bus.out_ready = 1'b0;
        drive(32'h01095024, mk(ALU_AND, 1'b1, 1'b0, BSEL_RT, 5'd0, 32'h00005024, 1'b0));
        cycle();
        drive(32'h01095026, mk(ALU_XOR, 1'b1, 1'b0, BSEL_RT, 5'd0, 32'h00005026, 1'b0));
        cycle();
        chk("pre_flush_full", 64'(bus.in_ready), 64'd0);
        drive(32'h01095027, mk(ALU_NOR, 1'b1, 1'b0, BSEL_RT, 5'd0, 32'h00005027, 1'b0));
        bus.flush = 1'b1;
        cycle();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        repeat (3) cycle();
        chk("flush_stays_empty", 64'(bus.out_valid), 64'd0);

        // assorted opcodes, streamed
        drive(32'hFC000000, mk(ALU_ADD, 1'b0, 1'b0, BSEL_RT, 5'd0, 32'h00000000, 1'b1)); cycle();
        drive(32'h05200003, mk(ALU_LT, 1'b1, 1'b0, BSEL_ZERO, 5'd0, 32'h00000003, 1'b0)); cycle();
        drive(32'h05210005, mk(ALU_GEZ, 1'b1, 1'b0, BSEL_ZERO, 5'd0, 32'h00000005, 1'b0)); cycle();
        drive(32'h05220000, mk(ALU_ADD, 1'b0, 1'b0, BSEL_RT, 5'd0, 32'h00000000, 1'b1)); cycle();
        drive(32'h11090004, mk(ALU_EQ, 1'b1, 1'b0, BSEL_RT, 5'd0, 32'h00000004, 1'b0)); cycle();
        drive(32'h3128F000, mk(ALU_AND, 1'b0, 1'b0, BSEL_IMM, 5'd0, 32'h0000F000, 1'b0)); cycle();
        drive(32'h8D28FFF0, mk(ALU_ADD, 1'b0, 1'b0, BSEL_IMM, 5'd0, 32'hFFFFFFF0, 1'b0)); cycle();
        drive(32'h01095007, mk(ALU_SRA, 1'b1, 1'b0, BSEL_RT, 5'd0, 32'h00005007, 1'b0)); cycle();
        drive(32'h01095001, mk(ALU_ADD, 1'b0, 1'b0, BSEL_RT, 5'd0, 32'h00005001, 1'b1)); cycle();
        drive(32'h0C000010, mk(ALU_ADD, 1'b0, 1'b0, BSEL_RT, 5'd0, 32'h00000010, 1'b0)); cycle();
        bus.in_valid = 1'b0;
        drain();

        // asynchronous reset between edges
        bus.out_ready = 1'b0;
        drive(32'h1D000002, mk(ALU_GTZ, 1'b1, 1'b0, BSEL_ZERO, 5'd0, 32'h00000002, 1'b0));
        cycle();
        bus.in_valid = 1'b0;
        chk("pre_areset_valid", 64'(bus.out_valid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        exp_q.delete();
        chk("areset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("areset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("areset_bundle", 64'(cur_obs()), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drive(32'h00094082, mk(ALU_SRL, 1'b1, 1'b1, BSEL_RT, 5'd2, 32'h00004082, 1'b0));
        cycle();
        bus.in_valid = 1'b0;
        chk("post_reset_latency", 64'(bus.out_valid), 64'd1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
